ram_arbiter: RTL and testbench

- Shares one single-port synchronous-write, asynchronous-read RAM (ADDR_WIDTH/DATA_WIDTH geometry, depth 1 << ADDR_WIDTH) between two requesters, A and B.
- Performs a post-reset clear sweep, then arbitrates round-robin, one access per cycle.
- Registers read data back to the winning requester.
- Sits directly in front of the RAM; requesters never drive RAM pins themselves.

---
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/ram_arbiter.sv | 116 +++++++++++
 tb/tb_ram_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: one requester's access channel into ram_arbiter.
//   master modport (requester): drives req, we, addr, wdata; sees gnt, rvalid, rdata
//   slave  modport (arbiter)  : sees req, we, addr, wdata; drives gnt, rvalid, rdata
//   req/we/addr/wdata : access request, 1 = write / 0 = read, address, write data
//   gnt               : request accepted this cycle (combinational)
//   rvalid            : one-cycle pulse, rdata holds the read result
//   rdata             : registered read data, held until the next read completes
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM (sync write, async read) between
// requesters A and B. After reset it optionally zero-fills the RAM, then
// grants one access per cycle round-robin and registers read data back.
//   clk, rst      : clock, synchronous active-high reset
//   busy          : high while the clear sweep runs; requests are ignored
//   a, b          : requester channels (ram_arbiter_if slave modport)
//   ram_wr_en     : RAM write enable
//   ram_addr      : RAM address
//   ram_d_in      : RAM write data
//   ram_d_out     : RAM asynchronous read data
//
// state   | meaning
// S_CLEAR | zero-fill sweep, one address per cycle, busy = 1
// S_ARB   | round-robin arbitration, one access per cycle
module ram_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  ram_arbiter_if.slave          a,
  ram_arbiter_if.slave          b,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_d_in,
  input  logic [DATA_WIDTH-1:0] ram_d_out
);

  typedef enum logic {S_CLEAR, S_ARB} state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_ARB;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  last_b;       // 1 = B won the most recent grant
  logic                  win_a, win_b;
  logic                  a_rvalid_q, b_rvalid_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RESET_STATE;
      clr_addr   <= '0;
      last_b     <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      // wraps back to 0 on the last sweep write, ready for the next reset
      if (state == S_CLEAR)
        clr_addr <= clr_addr + 1'b1;
      if (win_a)
        last_b <= 1'b0;
      else if (win_b)
        last_b <= 1'b1;
      a_rvalid_q <= win_a & ~a.we;
      b_rvalid_q <= win_b & ~b.we;
      if (win_a && !a.we)
        a_rdata_q <= ram_d_out;
      if (win_b && !b.we)
        b_rdata_q <= ram_d_out;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    win_a     = 1'b0;
    win_b     = 1'b0;
    ram_wr_en = 1'b0;
    ram_addr  = '0;
    ram_d_in  = '0;
    if (rst) begin
      // reset is sampled this cycle: no grants, no RAM writes
      busy = CLEAR_ON_RESET;
    end else begin
      case (state)
        S_CLEAR: begin
          busy      = 1'b1;
          ram_wr_en = 1'b1;
          ram_addr  = clr_addr;
          if (clr_addr == '1)
            state_nxt = S_ARB;
        end
        S_ARB: begin
          // on a tie the requester that did not win last time goes first
          win_a = a.req & (~b.req | last_b);
          win_b = b.req & (~a.req | ~last_b);
          if (win_a) begin
            ram_wr_en = a.we;
            ram_addr  = a.addr;
            ram_d_in  = a.wdata;
          end else if (win_b) begin
            ram_wr_en = b.we;
            ram_addr  = b.addr;
            ram_d_in  = b.wdata;
          end
        end
        default: state_nxt = RESET_STATE;
      endcase
    end
  end

  assign a.gnt    = win_a;
  assign b.gnt    = win_b;
  // a read completion still in flight when reset arrives is dropped
  assign a.rvalid = a_rvalid_q & ~rst;
  assign b.rvalid = b_rvalid_q & ~rst;
  assign a.rdata  = a_rdata_q;
  assign b.rdata  = b_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1: clear on reset ----------------
  logic          rst, fill, busy;
  logic          ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_d_in, ram_d_out;
  logic [DW-1:0] mem [DEPTH];

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia();
  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .busy(busy), .a(ia), .b(ib),
    .ram_wr_en(ram_wr_en), .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
  );

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hFF;
    end else if (ram_wr_en) begin
      mem[ram_addr] <= ram_d_in;
    end
  end
  assign ram_d_out = mem[ram_addr];

  // ---------------- DUT 2: no clear on reset ----------------
  logic          rst2, fill2, busy2;
  logic          ram2_wr_en;
  logic [AW-1:0] ram2_addr;
  logic [DW-1:0] ram2_d_in, ram2_d_out;
  logic [DW-1:0] mem2 [DEPTH];

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ia2();
  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ib2();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .rst(rst2), .busy(busy2), .a(ia2), .b(ib2),
    .ram_wr_en(ram2_wr_en), .ram_addr(ram2_addr), .ram_d_in(ram2_d_in), .ram_d_out(ram2_d_out)
  );

  always @(posedge clk) begin
    if (fill2) begin
      for (int i = 0; i < DEPTH; i++) mem2[i] <= 8'h3C;
    end else if (ram2_wr_en) begin
      mem2[ram2_addr] <= ram2_d_in;
    end
  end
  assign ram2_d_out = mem2[ram2_addr];

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            busy_left = 0;
  int            model_last = 1;     // 0 = A won last, 1 = B won last
  bit            granted_a, granted_b;

  // Evaluates the current cycle against the model, then advances to the next negedge.
  task automatic step();
    int win;
    #1;
    granted_a = 1'b0;
    granted_b = 1'b0;
    if (rst) begin
      chk("busy_in_reset", busy, 1);
      chk("a_gnt_in_reset", ia.gnt, 0);
      chk("b_gnt_in_reset", ib.gnt, 0);
      chk("wr_en_in_reset", ram_wr_en, 0);
      qa.delete();
      qb.delete();
      busy_left  = DEPTH;
      model_last = 1;
    end else if (busy_left > 0) begin
      chk("busy_sweep", busy, 1);
      chk("a_gnt_sweep", ia.gnt, 0);
      chk("b_gnt_sweep", ib.gnt, 0);
      chk("wr_en_sweep", ram_wr_en, 1);
      chk("addr_sweep", ram_addr, DEPTH - busy_left);
      chk("din_sweep", ram_d_in, 0);
      model_mem[DEPTH - busy_left] = '0;
      busy_left--;
    end else begin
      chk("busy_arb", busy, 0);
      win = 0;
      if (ia.req && ib.req) win = (model_last == 1) ? 1 : 2;
      else if (ia.req)      win = 1;
      else if (ib.req)      win = 2;
      chk("a_gnt", ia.gnt, (win == 1));
      chk("b_gnt", ib.gnt, (win == 2));
      if (win == 1) begin
        granted_a = 1'b1;
        chk("wr_en_a", ram_wr_en, ia.we);
        chk("addr_a", ram_addr, ia.addr);
        chk("din_a", ram_d_in, ia.wdata);
        if (ia.we) model_mem[ia.addr] = ia.wdata;
        else       qa.push_back('{due: cyc + 1, data: model_mem[ia.addr]});
        model_last = 0;
      end else if (win == 2) begin
        granted_b = 1'b1;
        chk("wr_en_b", ram_wr_en, ib.we);
        chk("addr_b", ram_addr, ib.addr);
        chk("din_b", ram_d_in, ib.wdata);
        if (ib.we) model_mem[ib.addr] = ib.wdata;
        else       qb.push_back('{due: cyc + 1, data: model_mem[ib.addr]});
        model_last = 1;
      end else begin
        chk("wr_en_idle", ram_wr_en, 0);
      end
    end
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #3;
    if (ia.rvalid) begin
      if (qa.size() == 0 || qa[0].due != cyc) begin
        chk("a_rvalid_unexpected", 1, 0);
      end else begin
        chk("a_rdata", ia.rdata, qa[0].data);
        void'(qa.pop_front());
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      chk("a_rvalid_missing", 0, 1);
      void'(qa.pop_front());
    end
    if (ib.rvalid) begin
      if (qb.size() == 0 || qb[0].due != cyc) begin
        chk("b_rvalid_unexpected", 1, 0);
      end else begin
        chk("b_rdata", ib.rdata, qb[0].data);
        void'(qb.pop_front());
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      chk("b_rvalid_missing", 0, 1);
      void'(qb.pop_front());
    end
  end

  task automatic set_a(input bit req, input bit we, input int addr, input int wdata);
    ia.req = req; ia.we = we; ia.addr = AW'(addr); ia.wdata = DW'(wdata);
  endtask

  task automatic set_b(input bit req, input bit we, input int addr, input int wdata);
    ib.req = req; ib.we = we; ib.addr = AW'(addr); ib.wdata = DW'(wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_grants;
    int b_grants;
    rst = 1'b1; fill = 1'b1;
    rst2 = 1'b1; fill2 = 1'b1;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    ia2.req = 1'b0; ia2.we = 1'b0; ia2.addr = '0; ia2.wdata = '0;
    ib2.req = 1'b0; ib2.we = 1'b0; ib2.addr = '0; ib2.wdata = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'hFF;
    @(negedge clk);
    step();
    fill = 1'b0; fill2 = 1'b0;
    step();
    rst = 1'b0;

    // clear sweep: requests during busy are ignored and not queued
    set_a(1, 0, 5, 0);
    set_b(1, 1, 6, 8'h77);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 8) begin set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); end
      step();
    end
    chk("busy_after_sweep", busy, 0);

    // read of a cleared location
    set_a(1, 0, 7, 0); step();
    set_a(0, 0, 0, 0); step();

    // single requester write then read
    set_a(1, 1, 3, 8'hA5); step();
    set_a(1, 0, 3, 0);     step();
    set_a(0, 0, 0, 0);     step();

    // contention: preload then both reading for 6 cycles
    set_a(1, 1, 1, 8'h11); step();
    set_a(0, 0, 0, 0);
    set_b(1, 1, 2, 8'h22); step();
    set_a(1, 0, 1, 0);
    set_b(1, 0, 2, 0);
    a_grants = 0; b_grants = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (granted_a) a_grants++;
      if (granted_b) b_grants++;
    end
    chk("alt_a_grants", a_grants, 3);
    chk("alt_b_grants", b_grants, 3);
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); step();

    // cross-requester write-then-read ordering
    set_a(1, 1, 9, 8'h5C); step();
    set_a(0, 0, 0, 0);
    set_b(1, 0, 9, 0);     step();
    set_b(0, 0, 0, 0);     step();

    // reset the cycle after a read grant
    set_a(1, 0, 3, 0); step();
    set_a(0, 0, 0, 0);
    rst = 1'b1;        step();
    rst = 1'b0;
    #1;
    chk("rdata_after_reset", ia.rdata, 0);
    chk("rvalid_after_reset", ia.rvalid, 0);
    chk("busy_after_reset", busy, 1);
    for (int i = 0; i < DEPTH; i++) step();

    // randomized traffic with occasional reset
    for (int n = 0; n < 500; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      if (!(ia.req && !granted_a) || $urandom_range(0, 3) == 0 && granted_a)
        set_a($urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      if (!(ib.req && !granted_b) || $urandom_range(0, 3) == 0 && granted_b)
        set_b($urandom_range(0, 2) != 0, $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
      step();
    end
    rst = 1'b0;
    set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) step();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    // no clear on reset: granted immediately after reset
    ia2.req = 1'b1; ia2.we = 1'b0; ia2.addr = 4'd0;
    #1;
    chk("nc_gnt_in_reset", ia2.gnt, 0);
    chk("nc_wr_en_in_reset", ram2_wr_en, 0);
    chk("nc_busy_in_reset", busy2, 0);
    @(negedge clk);
    rst2 = 1'b0;
    #1;
    chk("nc_busy", busy2, 0);
    chk("nc_a_gnt_first", ia2.gnt, 1);
    chk("nc_b_gnt", ib2.gnt, 0);
    @(negedge clk);
    ia2.req = 1'b0;
    #1;
    chk("nc_a_rvalid", ia2.rvalid, 1);
    chk("nc_a_rdata", ia2.rdata, 8'h3C);
    chk("nc_b_rvalid", ib2.rvalid, 0);
    @(negedge clk);
    #1;
    chk("nc_a_rvalid_pulse", ia2.rvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
